// File: rtl/gate_bist_controller.sv
// Self-test sequencer for the two-input basic-gate block: sweeps all {a,b} vectors,
// compares the seven gate outputs against the truth table and reports pass/fail.
module gate_bist_controller #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned LOOPS         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       a_o,
    output logic       b_o,
    input  logic [6:0] gates_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_mask,
    output logic [7:0] err_count,
    output logic [1:0] first_fail_vec
);

    typedef enum logic [2:0] {StIdle, StApply, StSettle, StCheck, StDone} state_e;

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES);
    localparam logic [3:0] LastLoop   = 4'(LOOPS - 1);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] loop_q, loop_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d, b_q, b_d;
    logic       pass_q, pass_d;
    logic [6:0] mask_q, mask_d;
    logic [7:0] err_q, err_d;
    logic [1:0] ffv_q, ffv_d;

    logic [6:0] expected;
    logic [6:0] mism;

    always_comb begin
        expected = {~(a_q ^ b_q), a_q ^ b_q, ~(a_q | b_q), ~(a_q & b_q), ~a_q, a_q | b_q, a_q & b_q};
        mism     = gates_i ^ expected;

        state_d = state_q;
        idx_d   = idx_q;
        loop_d  = loop_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        pass_d  = pass_q;
        mask_d  = mask_q;
        err_d   = err_q;
        ffv_d   = ffv_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StApply;
                    idx_d   = 2'd0;
                    loop_d  = 4'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    pass_d  = 1'b0;
                    mask_d  = 7'd0;
                    err_d   = 8'd0;
                    ffv_d   = 2'd0;
                end
            end
            StApply: begin
                cnt_d   = SettleLoad;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q <= 4'd1) begin
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCheck: begin
                if (mism != 7'd0) begin
                    mask_d = mask_q | mism;
                    if (err_q != 8'hff) err_d = err_q + 8'd1;
                    if (err_q == 8'd0) ffv_d = {a_q, b_q};
                end
                if (idx_q != 2'd3) begin
                    // Drive the next vector together with the APPLY entry.
                    idx_d   = idx_q + 2'd1;
                    a_d     = idx_d[1];
                    b_d     = idx_d[0];
                    state_d = StApply;
                end else if (loop_q < LastLoop) begin
                    idx_d   = 2'd0;
                    loop_d  = loop_q + 4'd1;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    state_d = StApply;
                end else begin
                    pass_d  = (err_d == 8'd0);
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort discards whatever the current cycle would have done, partial results kept.
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            pass_d  = 1'b0;
            a_d     = a_q;
            b_d     = b_q;
            mask_d  = mask_q;
            err_d   = err_q;
            ffv_d   = ffv_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            loop_q  <= 4'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= 7'd0;
            err_q   <= 8'd0;
            ffv_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            loop_q  <= loop_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
        end
    end

    assign a_o            = a_q;
    assign b_o            = b_q;
    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StDone);
    assign pass           = pass_q;
    assign fail_mask      = mask_q;
    assign err_count      = err_q;
    assign first_fail_vec = ffv_q;

endmodule
